// File: rtl/riscv_pkg.sv
// Shared RV32I core constants used across pipeline stages.
// Holds the bubble instruction, instruction width and PC step.
package riscv_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned PC_INCR     = 4;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between fetch and imem.
// master: drives imem_addr, takes imem_rdata; slave: the memory side.
interface fetch_stage_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_stage_pc_next_reg.sv
// PC register with next-PC select and +4 adder.
// Ports: clk, rst, StallF, PCSrcE, PCTargetE in; PCF, PCPlus4F out.
import riscv_pkg::*;

module pc_next_reg #(
    parameter int                    ADDRESS_WIDTH = 8,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     StallF,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    output logic [ADDRESS_WIDTH-1:0] PCF,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4F
);

    logic [ADDRESS_WIDTH-1:0] pcNextF;

    // Wraps modulo 2^ADDRESS_WIDTH.
    assign PCPlus4F = PCF + ADDRESS_WIDTH'(PC_INCR);

    // Redirect targets are forced word aligned.
    assign pcNextF = PCSrcE ? {PCTargetE[ADDRESS_WIDTH-1:2], 2'b00}
                            : PCPlus4F;

    // A redirect overrides a fetch stall.
    always_ff @(posedge clk) begin
        if (rst)
            PCF <= RESET_PC;
        else if (PCSrcE || !StallF)
            PCF <= pcNextF;
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, imem address, IF/ID pipeline register.
// Ports: clk, rst, hazard controls, redirect, imem bus, IF/ID outputs.
import riscv_pkg::*;

module fetch_stage #(
    parameter int                    ADDRESS_WIDTH = 8,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     StallF,
    input  logic                     StallD,
    input  logic                     FlushD,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    fetch_stage_if.master            imem,
    output logic [ADDRESS_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0]    InstrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     ValidD
);

    logic [ADDRESS_WIDTH-1:0] pcPlus4F;

    pc_next_reg #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .RESET_PC     (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .StallF   (StallF),
        .PCSrcE   (PCSrcE),
        .PCTargetE(PCTargetE),
        .PCF      (PCF),
        .PCPlus4F (pcPlus4F)
    );

    assign imem.imem_addr = PCF;

    // Flush beats stall: a flushed slot always becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            InstrD   <= DATA_WIDTH'(NOP_INSTR);
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= imem.imem_rdata;
            PCD      <= PCF;
            PCPlus4D <= pcPlus4F;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// imem model returns the zero-extended byte address as the word.
module tb_fetch_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       StallF, StallD, FlushD, PCSrcE;
    logic [7:0] PCTargetE;
    logic [7:0] PCF, PCD, PCPlus4D;
    logic [31:0] InstrD;
    logic       ValidD;

    int checks = 0;
    int failures = 0;

    fetch_stage_if #(.AW(8), .DW(32)) bus ();

    assign bus.imem_rdata = 32'(bus.imem_addr);

    fetch_stage #(
        .ADDRESS_WIDTH(8),
        .DATA_WIDTH   (32),
        .RESET_PC     (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .StallF   (StallF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .PCSrcE   (PCSrcE),
        .PCTargetE(PCTargetE),
        .imem     (bus),
        .PCF      (PCF),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        StallF = 0; StallD = 0; FlushD = 0;
        PCSrcE = 0; PCTargetE = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_ctl();
        step();
        step();
        checks++;
        if (PCF !== 8'h00 || bus.imem_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_pc: PCF=%h imem_addr=%h want 00", PCF, bus.imem_addr);
        end
        checks++;
        if (InstrD !== 32'h13 || PCD !== 8'h00 || PCPlus4D !== 8'h00 || ValidD !== 1'b0) begin
            failures++;
            $display("FAIL reset_ifid: InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b want 13/00/00/0",
                     InstrD, PCD, PCPlus4D, ValidD);
        end
    endtask

    task automatic test_sequential();
        rst = 0;
        step();
        checks++;
        if (PCF !== 8'h04 || InstrD !== 32'h0 || PCD !== 8'h00 ||
            PCPlus4D !== 8'h04 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL seq_first: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b want 04/0/00/04/1",
                     PCF, InstrD, PCD, PCPlus4D, ValidD);
        end
        step();
        checks++;
        if (PCF !== 8'h08 || InstrD !== 32'h4 || PCD !== 8'h04 || PCPlus4D !== 8'h08) begin
            failures++;
            $display("FAIL seq_second: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h want 08/4/04/08",
                     PCF, InstrD, PCD, PCPlus4D);
        end
    endtask

    task automatic test_redirect_flush();
        PCSrcE = 1; PCTargetE = 8'h40; FlushD = 1;
        step();
        clear_ctl();
        checks++;
        if (PCF !== 8'h40 || InstrD !== 32'h13 || ValidD !== 1'b0 || PCD !== 8'h00) begin
            failures++;
            $display("FAIL redirect_bubble: PCF=%h InstrD=%h ValidD=%b PCD=%h want 40/13/0/00",
                     PCF, InstrD, ValidD, PCD);
        end
        step();
        checks++;
        if (PCF !== 8'h44 || InstrD !== 32'h40 || PCD !== 8'h40 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL redirect_target: PCF=%h InstrD=%h PCD=%h ValidD=%b want 44/40/40/1",
                     PCF, InstrD, PCD, ValidD);
        end
    endtask

    task automatic test_stall();
        PCSrcE = 1; PCTargetE = 8'h0C;
        step();
        clear_ctl();
        checks++;
        if (PCF !== 8'h0C || InstrD !== 32'h44 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL redirect_noflush: PCF=%h InstrD=%h ValidD=%b want 0C/44/1",
                     PCF, InstrD, ValidD);
        end
        step();
        StallF = 1; StallD = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (PCF !== 8'h10 || bus.imem_addr !== 8'h10 || InstrD !== 32'h0C ||
                PCD !== 8'h0C || PCPlus4D !== 8'h10 || ValidD !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: PCF=%h addr=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b want 10/10/0C/0C/10/1",
                         i, PCF, bus.imem_addr, InstrD, PCD, PCPlus4D, ValidD);
            end
        end
        clear_ctl();
        step();
        checks++;
        if (PCF !== 8'h14 || InstrD !== 32'h10 || PCD !== 8'h10) begin
            failures++;
            $display("FAIL stall_resume: PCF=%h InstrD=%h PCD=%h want 14/10/10",
                     PCF, InstrD, PCD);
        end
    endtask

    task automatic test_priority();
        StallF = 1; StallD = 1; FlushD = 1;
        PCSrcE = 1; PCTargetE = 8'h80;
        step();
        clear_ctl();
        checks++;
        if (PCF !== 8'h80) begin
            failures++;
            $display("FAIL redirect_over_stall: PCF=%h want 80", PCF);
        end
        checks++;
        if (InstrD !== 32'h13 || ValidD !== 1'b0 || PCD !== 8'h00 || PCPlus4D !== 8'h00) begin
            failures++;
            $display("FAIL flush_over_stall: InstrD=%h ValidD=%b PCD=%h PCPlus4D=%h want 13/0/00/00",
                     InstrD, ValidD, PCD, PCPlus4D);
        end
    endtask

    task automatic test_align_wrap();
        PCSrcE = 1; PCTargetE = 8'h23;
        step();
        clear_ctl();
        checks++;
        if (PCF !== 8'h20) begin
            failures++;
            $display("FAIL target_align: PCF=%h want 20", PCF);
        end
        PCSrcE = 1; PCTargetE = 8'hFC;
        step();
        clear_ctl();
        checks++;
        if (PCF !== 8'hFC) begin
            failures++;
            $display("FAIL to_top: PCF=%h want FC", PCF);
        end
        step();
        checks++;
        if (PCF !== 8'h00 || InstrD !== 32'hFC || PCD !== 8'hFC || PCPlus4D !== 8'h00) begin
            failures++;
            $display("FAIL pc_wrap: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h want 00/FC/FC/00",
                     PCF, InstrD, PCD, PCPlus4D);
        end
        step();
        checks++;
        if (PCF !== 8'h04 || InstrD !== 32'h0 || PCD !== 8'h00 || PCPlus4D !== 8'h04) begin
            failures++;
            $display("FAIL after_wrap: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h want 04/0/00/04",
                     PCF, InstrD, PCD, PCPlus4D);
        end
    endtask

    task automatic test_reset_mid();
        PCSrcE = 1; PCTargetE = 8'h2C;
        step();
        clear_ctl();
        step();
        checks++;
        if (PCF !== 8'h30 || InstrD !== 32'h2C || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: PCF=%h InstrD=%h ValidD=%b want 30/2C/1",
                     PCF, InstrD, ValidD);
        end
        rst = 1; StallF = 1; StallD = 1;
        PCSrcE = 1; PCTargetE = 8'h80;
        step();
        checks++;
        if (PCF !== 8'h00 || InstrD !== 32'h13 || ValidD !== 1'b0 ||
            PCD !== 8'h00 || PCPlus4D !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: PCF=%h InstrD=%h ValidD=%b PCD=%h PCPlus4D=%h want 00/13/0/00/00",
                     PCF, InstrD, ValidD, PCD, PCPlus4D);
        end
        rst = 0;
        clear_ctl();
        step();
        checks++;
        if (PCF !== 8'h04 || InstrD !== 32'h0 || ValidD !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: PCF=%h InstrD=%h ValidD=%b want 04/0/1",
                     PCF, InstrD, ValidD);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_flush();
        test_stall();
        test_priority();
        test_align_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipelined RV32I core. Holds the program counter, selects sequential or redirected next PC, drives the instruction-memory read address, and registers the fetched instruction with its PC into the IF/ID pipeline register that feeds decode. Honours stall and flush requests from the hazard unit and redirects from execute.

## Interface

Parameters:
- ADDRESS_WIDTH, 8, PC and instruction-memory byte-address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID register
- FlushD  in  1  replace IF/ID contents with a bubble
- PCSrcE  in  1  redirect taken (branch/jump resolved in execute)
- PCTargetE  in  ADDRESS_WIDTH  redirect target from execute
- imem_addr  out  ADDRESS_WIDTH  instruction-memory read address (= PCF)
- imem_rdata  in  DATA_WIDTH  instruction word, combinational read of imem_addr
- PCF  out  ADDRESS_WIDTH  current fetch PC (debug / pc_addr tap)
- InstrD  out  DATA_WIDTH  registered instruction to decode
- PCD  out  ADDRESS_WIDTH  registered PC of InstrD
- PCPlus4D  out  ADDRESS_WIDTH  registered PC+4 of InstrD
- ValidD  out  1  InstrD is a real fetched instruction (0 = bubble)

## Operation

- PCPlus4F = PCF + 4, modulo 2^ADDRESS_WIDTH (wraps silently).
- PCNextF = PCSrcE ? {PCTargetE[AW-1:2], 2'b00} : PCPlus4F; low two target bits always forced to 0.
- PC register, priority: rst -> RESET_PC; else PCSrcE -> PCNextF (redirect overrides StallF); else StallF -> hold; else PCPlus4F.
- IF/ID register, priority: rst -> bubble; else FlushD -> bubble; else StallD -> hold all four fields; else load {imem_rdata, PCF, PCPlus4F, 1}.
- Bubble = InstrD 0x00000013 (addi x0,x0,0), PCD 0, PCPlus4D 0, ValidD 0.
- imem_addr = PCF, combinational; no other read enable.
- Block does not decode instructions and does not generate FlushD itself; the hazard unit asserts FlushD alongside PCSrcE.

## Timing

- Reset values: PCF = RESET_PC, imem_addr = RESET_PC, InstrD = 0x00000013, PCD = 0, PCPlus4D = 0, ValidD = 0.
- First real instruction (at RESET_PC) appears on InstrD one cycle after rst deasserts, ValidD = 1.
- Latency imem_addr -> InstrD: 1 cycle.
- Redirect: PCSrcE high in cycle N -> PCF = target in N+1; target instruction on InstrD in N+2. Wrong-path instruction fetched in N is discarded only if FlushD is high in N.
- StallF and StallD together: PCF, InstrD, PCD, PCPlus4D, ValidD all unchanged next cycle; imem_addr stable.
- FlushD and StallD together: flush wins (bubble loaded).
- PCSrcE and StallF together: redirect wins.
- rst asserted mid-operation: next edge restores all reset values regardless of other inputs.
- PCF = 2^AW - 4, no redirect: PCF -> 0 next cycle.

## Structure

- Shared package riscv_pkg: NOP_INSTR (32'h00000013), INSTR_WIDTH constant, PC increment constant 4.
- One natural sub-module: pc_next_reg (PC register plus next-PC select and +4 adder); IF/ID register lives in fetch_stage.

## Test plan

- Reset then run 4 cycles, imem returns word = addr: PCF 0,4,8,12; InstrD 0x0,0x4,0x8 from cycle 2; ValidD rises cycle after rst low.
- At PCF = 8 assert PCSrcE with PCTargetE = 0x40 and FlushD one cycle: PCF = 0x40 next; InstrD bubble (0x13, ValidD 0) next; instruction from 0x40 following cycle.
- StallF+StallD for 3 cycles at PCF = 0x10: PCF and InstrD frozen, imem_addr = 0x10 throughout; resume with PCF = 0x14.
- FlushD with StallD, and PCSrcE with StallF, same cycle: bubble loaded, PCF = target.
- PCTargetE = 0x23: PCF = 0x20. PCF = 0xFC (AW = 8), no redirect: PCF = 0x00, PCPlus4D of that fetch = 0x00.
- Assert rst while stalled at PCF = 0x30 with valid InstrD: next edge PCF = RESET_PC, InstrD = 0x13, ValidD 0.
